i2c_target_ctrl: RTL

I2C_TARGET_CTRL -- requirements
Module: i2c_target_ctrl

---
 rtl/i2c_target_if.sv | 25 ++
 rtl/i2c_target_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_if.sv
// I2C pin and memory-port bundle between the target controller
// and its surroundings (pins, 128x8 memory).
interface i2c_target_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_we;
  logic       mem_re;
  logic       busy;

  modport master (
    output scl_in, sda_in, mem_rdata,
    input  sda_oe, mem_addr, mem_wdata,
    input  mem_we, mem_re, busy
  );

  modport slave (
    input  scl_in, sda_in, mem_rdata,
    output sda_oe, mem_addr, mem_wdata,
    output mem_we, mem_re, busy
  );
endinterface

// File: rtl/i2c_target_ctrl.sv
// I2C target with 7-bit register pointer into a 128x8 memory.
// Pins are synchronized; all protocol decisions use clock-domain edges.
module i2c_target_ctrl #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input logic clock,
  input logic reset_n,
  i2c_target_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, DEVADDR, DEVACK, PTR, PTRACK,
    WRDATA, WRACK, RDDATA, RDACK, IGNORE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] scl_sync_q, scl_sync_d;
  logic [2:0] sda_sync_q, sda_sync_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [6:0] tx_q, tx_d;
  logic [6:0] ptr_q, ptr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       busy_q, busy_d;

  logic scl_rise, scl_fall, start, stop, sda;

  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], bus.scl_in};
    sda_sync_d = {sda_sync_q[1:0], bus.sda_in};
    sda      = sda_sync_q[1];
    scl_rise = scl_sync_q[1] & ~scl_sync_q[2];
    scl_fall = ~scl_sync_q[1] & scl_sync_q[2];
    start    = sda_sync_q[2] & ~sda & scl_sync_q[1];
    stop     = ~sda_sync_q[2] & sda & scl_sync_q[1];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    ptr_d   = ptr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    busy_d  = busy_q;
    // pointer advances once the write strobe has been seen
    if (we_q) ptr_d = ptr_q + 7'd1;
    unique case (1'b1)
      start: begin
        state_d = DEVADDR;
        cnt_d   = '0;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
      end
      stop: begin
        state_d = IDLE;
        cnt_d   = '0;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        unique case (state_q)
          DEVADDR: if (scl_rise) begin
            rx_d  = {rx_q[5:0], sda};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rw_d = sda;
              if (rx_q == DEV_ADDR) begin
                state_d = DEVACK;
                busy_d  = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end
          end
          DEVACK, PTRACK, WRACK: if (scl_fall) begin
            // first fall starts the ACK, second one ends it
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d  = 1'b0;
              cnt_d = '0;
              if (state_q != DEVACK) begin
                state_d = WRDATA;
              end else if (rw_q) begin
                state_d = RDDATA;
                re_d    = 1'b1;
              end else begin
                state_d = PTR;
              end
            end
          end
          PTR: if (scl_rise) begin
            rx_d  = {rx_q[5:0], sda};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ptr_d   = {rx_q[5:0], sda};
              state_d = PTRACK;
            end
          end
          WRDATA: if (scl_rise) begin
            rx_d  = {rx_q[5:0], sda};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              wdata_d = {rx_q, sda};
              we_d    = 1'b1;
              state_d = WRACK;
            end
          end
          RDDATA: begin
            if (re_q) begin
              tx_d = bus.mem_rdata[6:0];
              oe_d = ~bus.mem_rdata[7];
            end else if (scl_fall) begin
              if (cnt_q == 3'd7) begin
                oe_d    = 1'b0;
                cnt_d   = '0;
                state_d = RDACK;
              end else begin
                cnt_d = cnt_q + 3'd1;
                oe_d  = ~tx_q[6];
                tx_d  = {tx_q[5:0], 1'b0};
              end
            end
          end
          RDACK: begin
            if (scl_rise && cnt_q == 3'd0) begin
              ptr_d = ptr_q + 7'd1;
              if (sda) begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end else begin
                cnt_d = 3'd1;
              end
            end else if (scl_fall && cnt_q == 3'd1) begin
              re_d    = 1'b1;
              cnt_d   = '0;
              state_d = RDDATA;
            end
          end
          IDLE, IGNORE: ;
          default: state_d = IDLE;
        endcase
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      wdata_q    <= '0;
      rw_q       <= 1'b0;
      oe_q       <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
      re_q       <= re_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.sda_oe    = oe_q;
  assign bus.mem_addr  = ptr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_re    = re_q;
  assign bus.busy      = busy_q;
endmodule
